// File: rtl/control_pipe_pkg.sv
// Shared pipeline defines: opcodes, writeback/forward encodings, branch
// funct3 codes, the decode control bundle and the branch-condition helper.
package control_pipe_pkg;

    // Base-ISA major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int REG_W = 5;

    // Writeback result select
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    // ALU operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } forward_t;

    // Branch condition codes carried in funct3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Decode-stage control bundle as staged into E
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       sel_adder;
        logic [1:0] result_src;
    } ctrl_t;

    // Branch condition from funct3 and ALU flags; unknown codes never branch
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       lt);
        logic taken;
        // NOTE: default first so every path assigns; otherwise a latch is inferred.
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Hazard unit: load-use stall, control-flow flush and operand forwarding.
// Purely combinational from the current stage registers and decode inputs.
module hazard_detect
    import control_pipe_pkg::*;
(
    input  logic [1:0]       result_src_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] rd_m,
    input  logic             reg_write_w,
    input  logic [REG_W-1:0] rd_w,
    input  logic             pc_src_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e
);

    logic lw_stall;

    // Memory stage is checked first so the youngest producer wins; x0 never matches
    function automatic forward_t fwd_sel(input logic [REG_W-1:0] rs);
        if (reg_write_m && (rd_m != '0) && (rd_m == rs))
            return FWD_MEM;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    // Load in E whose destination feeds the instruction in D must wait a cycle
    assign lw_stall = (result_src_e == RES_MEM) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A redirect flushes D and E; a stall also bubbles E but holds F and D
    assign stall_f = lw_stall;
    assign stall_d = lw_stall;
    assign flush_d = pc_src_e;
    assign flush_e = lw_stall | pc_src_e;

    // Operand source selection for both ALU inputs
    assign forward_a_e = fwd_sel(rs1_e);
    assign forward_b_e = fwd_sel(rs2_e);

endmodule

// File: rtl/control_pipe.sv
// Control-path pipeline: stages decode controls through E, M and W,
// resolves branches in E and hosts the hazard unit.
module control_pipe
    import control_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic             sel_adder,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       funct3D,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] RdD,
    input  logic             ZeroE,
    input  logic             LtE,
    output logic             RegWriteE,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             MemWriteE,
    output logic             MemWriteM,
    output logic             ALUSrcE,
    output logic             sel_adderE,
    output logic [1:0]       ResultSrcE,
    output logic [1:0]       ResultSrcM,
    output logic [1:0]       ResultSrcW,
    output logic [REG_W-1:0] Rs1E,
    output logic [REG_W-1:0] Rs2E,
    output logic [REG_W-1:0] RdE,
    output logic [REG_W-1:0] RdM,
    output logic [REG_W-1:0] RdW,
    output logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
);

    typedef struct packed {
        ctrl_t            ctrl;
        logic [2:0]       funct3;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } e_stage_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic [1:0]       result_src;
        logic [REG_W-1:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic [REG_W-1:0] rd;
    } w_stage_t;

    e_stage_t e_d, e_q;
    m_stage_t m_q;
    w_stage_t w_q;

    // Gather the decode-stage inputs into the E-stage record
    always_comb begin
        e_d.ctrl.reg_write  = RegWriteD;
        e_d.ctrl.mem_write  = MemWriteD;
        e_d.ctrl.jump       = JumpD;
        e_d.ctrl.branch     = BranchD;
        e_d.ctrl.alu_src    = ALUSrcD;
        e_d.ctrl.sel_adder  = sel_adder;
        e_d.ctrl.result_src = ResultSrcD;
        e_d.funct3          = funct3D;
        e_d.rs1             = Rs1D;
        e_d.rs2             = Rs2D;
        e_d.rd              = RdD;
    end

    // D->E register: captures every cycle, loads an all-zero bubble on FlushE
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: async clear keeps controls from leaking out of a reset mid-flight.
        if (!rst)
            e_q <= '0;
        else if (FlushE)
            e_q <= '0;
        else
            // NOTE: non-blocking so every stage samples the pre-edge value of the one before.
            e_q <= e_d;
    end

    // E->M register: advances unconditionally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
        end else begin
            m_q.reg_write  <= e_q.ctrl.reg_write;
            m_q.mem_write  <= e_q.ctrl.mem_write;
            m_q.result_src <= e_q.ctrl.result_src;
            m_q.rd         <= e_q.rd;
        end
    end

    // M->W register: advances unconditionally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q <= '0;
        end else begin
            w_q.reg_write  <= m_q.reg_write;
            w_q.result_src <= m_q.result_src;
            w_q.rd         <= m_q.rd;
        end
    end

    // Redirect on a jump or a taken branch resolved in E
    assign PCSrcE = e_q.ctrl.jump |
                    (e_q.ctrl.branch & branch_cond(e_q.funct3, ZeroE, LtE));

    assign RegWriteE  = e_q.ctrl.reg_write;
    assign MemWriteE  = e_q.ctrl.mem_write;
    assign ALUSrcE    = e_q.ctrl.alu_src;
    assign sel_adderE = e_q.ctrl.sel_adder;
    assign ResultSrcE = e_q.ctrl.result_src;
    assign Rs1E       = e_q.rs1;
    assign Rs2E       = e_q.rs2;
    assign RdE        = e_q.rd;

    assign RegWriteM  = m_q.reg_write;
    assign MemWriteM  = m_q.mem_write;
    assign ResultSrcM = m_q.result_src;
    assign RdM        = m_q.rd;

    assign RegWriteW  = w_q.reg_write;
    assign ResultSrcW = w_q.result_src;
    assign RdW        = w_q.rd;

    hazard_detect u_hazard (
        .result_src_e (e_q.ctrl.result_src),
        .rd_e         (e_q.rd),
        .rs1_e        (e_q.rs1),
        .rs2_e        (e_q.rs2),
        .rs1_d        (Rs1D),
        .rs2_d        (Rs2D),
        .reg_write_m  (m_q.reg_write),
        .rd_m         (m_q.rd),
        .reg_write_w  (w_q.reg_write),
        .rd_w         (w_q.rd),
        .pc_src_e     (PCSrcE),
        .stall_f      (StallF),
        .stall_d      (StallD),
        .flush_d      (FlushD),
        .flush_e      (FlushE),
        .forward_a_e  (ForwardAE),
        .forward_b_e  (ForwardBE)
    );

endmodule

// File: tb/tb_control_pipe.sv
// Directed testbench for control_pipe: reset, latency, load-use, forwarding,
// branches, stall/flush overlap, x0 handling and asynchronous reset.
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, sel_adder;
    logic [1:0] ResultSrcD;
    logic [2:0] funct3D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       ZeroE, LtE;
    logic       RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, ALUSrcE, sel_adderE;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
    logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
    logic       PCSrcE, StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;

    int tests = 0;
    int fails = 0;

    control_pipe dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .sel_adder(sel_adder), .ResultSrcD(ResultSrcD), .funct3D(funct3D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE), .LtE(LtE),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM), .ALUSrcE(ALUSrcE), .sel_adderE(sel_adderE),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0; sel_adder = 0;
        ResultSrcD = 2'b00; funct3D = 3'b000; Rs1D = 0; Rs2D = 0; RdD = 0;
        ZeroE = 0; LtE = 0;
    endtask

    task automatic drain();
        clear_d();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        clear_d();
        RegWriteD = 1; MemWriteD = 1; JumpD = 1; ResultSrcD = 2'b01; RdD = 5; Rs1D = 5;
        rst = 1'b0;
        repeat (2) tick();
        tests++; if ({RegWriteE, MemWriteE, RegWriteM, MemWriteM, RegWriteW} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b want 00000", {RegWriteE, MemWriteE, RegWriteM, MemWriteM, RegWriteW}); end
        tests++; if ({RdE, RdM, RdW, ResultSrcE} !== 17'b0) begin fails++; $display("FAIL reset_regs got %h want 0", {RdE, RdM, RdW, ResultSrcE}); end
        tests++; if ({PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE} !== 9'b0) begin fails++; $display("FAIL reset_hazard got %b want 0", {PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}); end
        clear_d();
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        drain();
        JumpD = 1; RegWriteD = 1; ResultSrcD = 2'b10; RdD = 3; ALUSrcD = 1; sel_adder = 1;
        tick();
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL lat_pcsrc got %b want 1", PCSrcE); end
        tests++; if ({RegWriteE, ResultSrcE, ALUSrcE, sel_adderE, RdE} !== {1'b1, 2'b10, 1'b1, 1'b1, 5'd3}) begin fails++; $display("FAIL lat_e got %b want 1101100011", {RegWriteE, ResultSrcE, ALUSrcE, sel_adderE, RdE}); end
        tests++; if ({FlushD, FlushE, StallF} !== 3'b110) begin fails++; $display("FAIL lat_flush got %b want 110", {FlushD, FlushE, StallF}); end
        clear_d();
        tick();
        tests++; if ({RegWriteM, ResultSrcM, RdM, RegWriteW} !== {1'b1, 2'b10, 5'd3, 1'b0}) begin fails++; $display("FAIL lat_m got %b want 11000110", {RegWriteM, ResultSrcM, RdM, RegWriteW}); end
        tick();
        tests++; if ({RegWriteW, ResultSrcW, RdW} !== {1'b1, 2'b10, 5'd3}) begin fails++; $display("FAIL lat_w got %b want 11000011", {RegWriteW, ResultSrcW, RdW}); end
    endtask

    task automatic test_load_use();
        drain();
        RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5; Rs1D = 1; Rs2D = 2;
        tick();
        RegWriteD = 1; ResultSrcD = 2'b00; RdD = 8; Rs1D = 5; Rs2D = 6;
        #1;
        tests++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin fails++; $display("FAIL lu_stall got %b want 1110", {StallF, StallD, FlushE, FlushD}); end
        tick();
        tests++; if ({RegWriteE, ResultSrcE, RdE, Rs1E} !== 13'b0) begin fails++; $display("FAIL lu_bubble got %b want 0", {RegWriteE, ResultSrcE, RdE, Rs1E}); end
        tests++; if ({StallF, FlushE, RegWriteM, RdM} !== {1'b0, 1'b0, 1'b1, 5'd5}) begin fails++; $display("FAIL lu_after got %b want 00100101", {StallF, FlushE, RegWriteM, RdM}); end
        tick();
        tests++; if ({Rs1E, RdW, ForwardAE, ForwardBE} !== {5'd5, 5'd5, 2'b01, 2'b00}) begin fails++; $display("FAIL lu_fwd got %b want 00101001010100", {Rs1E, RdW, ForwardAE, ForwardBE}); end
    endtask

    // Build W=producer(7), M=producer(7, regwrite as given), E=consumer of 7
    task automatic fwd_sequence(input logic m_writes);
        drain();
        RegWriteD = 1; RdD = 7;
        tick();
        RegWriteD = m_writes; RdD = 7;
        tick();
        RegWriteD = 0; RdD = 0; Rs1D = 7; Rs2D = 7;
        tick();
    endtask

    task automatic test_forward_priority();
        fwd_sequence(1'b1);
        tests++; if ({ForwardAE, ForwardBE} !== 4'b1010) begin fails++; $display("FAIL fwd_mem_wins got %b want 1010", {ForwardAE, ForwardBE}); end
        fwd_sequence(1'b0);
        tests++; if ({ForwardAE, ForwardBE} !== 4'b0101) begin fails++; $display("FAIL fwd_wb got %b want 0101", {ForwardAE, ForwardBE}); end
    endtask

    task automatic test_branches();
        drain();
        BranchD = 1; funct3D = 3'b001;
        tick();
        ZeroE = 0; #1;
        tests++; if ({PCSrcE, FlushD, FlushE} !== 3'b111) begin fails++; $display("FAIL bne_taken got %b want 111", {PCSrcE, FlushD, FlushE}); end
        ZeroE = 1; funct3D = 3'b000; #1;
        tests++; if ({PCSrcE, FlushD, FlushE} !== 3'b000) begin fails++; $display("FAIL bne_not got %b want 000", {PCSrcE, FlushD, FlushE}); end
        tick();
        ZeroE = 0; #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL beq_not got %b want 0", PCSrcE); end
        ZeroE = 1; #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL beq_taken got %b want 1", PCSrcE); end
        ZeroE = 0; funct3D = 3'b010; #1;
        tick();
        ZeroE = 1; LtE = 1; #1;
        tests++; if ({PCSrcE, FlushD} !== 2'b00) begin fails++; $display("FAIL f3_010 got %b want 00", {PCSrcE, FlushD}); end
        ZeroE = 0; LtE = 0; #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL f3_010b got %b want 0", PCSrcE); end
        funct3D = 3'b100;
        tick();
        LtE = 1; #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL blt_taken got %b want 1", PCSrcE); end
        LtE = 0; #1;
        tests++; if (PCSrcE !== 1'b0) begin fails++; $display("FAIL blt_not got %b want 0", PCSrcE); end
        funct3D = 3'b101;
        tick();
        LtE = 0; #1;
        tests++; if (PCSrcE !== 1'b1) begin fails++; $display("FAIL bge_taken got %b want 1", PCSrcE); end
        BranchD = 0;
    endtask

    task automatic test_stall_flush_overlap();
        drain();
        JumpD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 9;
        tick();
        clear_d(); Rs2D = 9; #1;
        tests++; if ({PCSrcE, StallF, StallD, FlushD, FlushE} !== 5'b11111) begin fails++; $display("FAIL overlap got %b want 11111", {PCSrcE, StallF, StallD, FlushD, FlushE}); end
    endtask

    task automatic test_x0();
        drain();
        RegWriteD = 1; ResultSrcD = 2'b01; RdD = 0;
        tick();
        clear_d(); #1;
        tests++; if ({StallF, StallD, FlushE} !== 3'b000) begin fails++; $display("FAIL x0_stall got %b want 000", {StallF, StallD, FlushE}); end
        tick();
        tests++; if ({RegWriteM, RdM, Rs1E, ForwardAE, ForwardBE} !== {1'b1, 5'd0, 5'd0, 2'b00, 2'b00}) begin fails++; $display("FAIL x0_fwd got %b want 1 followed by zeros", {RegWriteM, RdM, Rs1E, ForwardAE, ForwardBE}); end
    endtask

    task automatic test_async_reset();
        drain();
        MemWriteD = 1; RegWriteD = 1; RdD = 4;
        tick();
        clear_d();
        tick();
        tests++; if (MemWriteM !== 1'b1) begin fails++; $display("FAIL ar_pre got %b want 1", MemWriteM); end
        #2 rst = 1'b0;
        #1;
        tests++; if ({MemWriteM, RegWriteM, RdM} !== 7'b0) begin fails++; $display("FAIL ar_async got %b want 0", {MemWriteM, RegWriteM, RdM}); end
        #1 rst = 1'b1;
        tick();
        tests++; if ({RegWriteE, RegWriteM, MemWriteM, RegWriteW, RdW} !== 9'b0) begin fails++; $display("FAIL ar_empty got %b want 0", {RegWriteE, RegWriteM, MemWriteM, RegWriteW, RdW}); end
    endtask

    initial begin
        rst = 1'b0;
        clear_d();
        test_reset();
        test_latency();
        test_load_use();
        test_forward_priority();
        test_branches();
        test_stall_flush_overlap();
        test_x0();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, sel_adder  input  1 each  decode-stage control bundle.
REQ-004 ResultSrcD  input  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
REQ-005 funct3D  input  3  branch condition; Rs1D, Rs2D, RdD  input  5 each  decode-stage register indices.
REQ-006 ZeroE, LtE  input  1 each  ALU flags: zero, signed less-than.
REQ-007 RegWriteE/M/W, MemWriteE/M, ALUSrcE, sel_adderE  output  1 each  staged controls.
REQ-008 ResultSrcE/M/W  output  2  staged writeback selects; Rs1E, Rs2E, RdE, RdM, RdW  output  5 each.
REQ-009 PCSrcE  output  1  redirect fetch to branch/jump target.
REQ-010 StallF, StallD, FlushD, FlushE  output  1 each  hazard controls.
REQ-011 ForwardAE, ForwardBE  output  2 each  operand source: 00 register file, 01 writeback, 10 memory stage.

Function
REQ-012 D->E register SHALL capture the bundle, funct3D, Rs1D, Rs2D and RdD each cycle unless FlushE is asserted.
REQ-013 With FlushE high, E SHALL load a bubble: all 1-bit controls 0, ResultSrcE 00, funct3E/Rs1E/Rs2E/RdE 0.
REQ-014 E->M and M->W SHALL advance unconditionally every cycle, with no stall or flush.
REQ-015 PCSrcE = JumpE | (BranchE & cond); cond per funct3E: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE, any other value 0.
REQ-016 Load-use lwStall SHALL be 1 when ResultSrcE==01, RdE!=0, and (RdE==Rs1D or RdE==Rs2D).
REQ-017 StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall | PCSrcE.
REQ-018 ForwardAE: 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00.
REQ-019 ForwardBE: same rule as REQ-018 using Rs2E.
REQ-020 When M and W both match, the memory stage SHALL win (10).
REQ-021 Hazard and forward outputs SHALL be combinational from current stage registers and D inputs, with zero latency.
REQ-022 Each control SHALL appear at E/M/W exactly 1/2/3 cycles after capture in D, absent flushes.
REQ-023 When lwStall and PCSrcE are asserted together, the flush SHALL dominate: FlushE=1 and FlushD=1; stall outputs still follow lwStall.
REQ-024 Register x0 SHALL never trigger a stall or forward.

Reset
REQ-025 While rst is low, all E/M/W registers SHALL be 0, asynchronously.
REQ-026 During reset, PCSrcE, stall, flush and forward outputs SHALL therefore be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight controls; the first post-reset cycle SHALL start from an empty pipe.

Structure
REQ-028 ResultSrc encodings, Forward encodings and branch funct3 codes SHALL live in the shared defines package next to the opcode constants.
REQ-029 Stall/flush/forward logic SHALL be one sub-module, hazard_detect; staging registers SHALL stay in control_pipe.

Verification
REQ-030 Load-use: lw with RdE=5, then add with Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle, bubble in E, then ForwardAE=01.
REQ-031 Forward priority: RdM=RdW=7, both RegWrite=1, Rs1E=7 -> ForwardAE=10; clear RegWriteM -> 01.
REQ-032 Branches: funct3 001 with ZeroE=0 -> PCSrcE=1, FlushD=FlushE=1; funct3 000 with ZeroE=0 -> PCSrcE=0; funct3 010 -> 0.
REQ-033 x0: lw with RdE=0, Rs1D=0 -> no stall; RdM=0, RegWriteM=1 -> ForwardAE=00.
REQ-034 Latency: JumpD=1, RegWriteD=1, ResultSrcD=10 -> RegWriteW=1 and ResultSrcW=10 three edges later; PCSrcE=1 after one edge.
REQ-035 Reset: drop rst while M holds MemWriteM=1 -> MemWriteM=0 immediately, without waiting for a clk edge.
